// File: rtl/pipeline_stall_controller_pkg.sv
// rtl/pipeline_stall_controller_pkg.sv - shared encodings for the pipeline stall controller
package pipeline_stall_controller_pkg;

  localparam int REG_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10,
    BR_JMP  = 2'b11
  } branch_t;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// rtl/pipeline_stall_controller_sat_counter.sv - saturating event counter with clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Clear wins over increment; stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - hold/bubble/flush sequencing with memory-wait freeze
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IF_ID_rs,
  input  logic [REG_W-1:0] IF_ID_rt,
  input  logic [REG_W-1:0] ID_EX_rt,
  input  logic             ID_EX_mem_read,
  input  logic [1:0]       branch,
  input  logic             equal,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             mux_hz_unit,
  output logic             flush,
  output logic             pipe_freeze,
  output logic             mem_error,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0] LP_TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_next_wait;
  logic       w_mem_stall;
  logic       w_load_use;
  logic       w_taken;

  assign w_mem_stall = mem_req & ~mem_ready;
  assign w_load_use  = ID_EX_mem_read && (ID_EX_rt != '0) &&
                       ((IF_ID_rs == ID_EX_rt) || (IF_ID_rt == ID_EX_rt));
  assign w_taken     = ((branch == BR_EQ) && equal) ||
                       ((branch == BR_NE) && !equal) ||
                       (branch == BR_JMP);

  // State and memory-wait cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait;
    end
  end

  // Next state and pipeline controls; freeze beats load-use beats taken branch.
  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    mux_hz_unit  = 1'b1;
    flush        = 1'b0;
    pipe_freeze  = 1'b0;
    w_next_state = r_state;
    w_next_wait  = r_wait_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          pipe_freeze  = 1'b1;
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          w_next_state = ST_MEM_WAIT;
          w_next_wait  = 8'd1;
        end else if (w_load_use) begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          mux_hz_unit = 1'b0;
        end else if (w_taken) begin
          flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          pipe_freeze = 1'b1;
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          if (r_wait_cnt == LP_TIMEOUT) begin
            w_next_state = ST_ERROR;
          end else begin
            w_next_wait = r_wait_cnt + 8'd1;
          end
        end else begin
          w_next_state = ST_RUN;
          w_next_wait  = '0;
          if (w_load_use) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            mux_hz_unit = 1'b0;
          end else if (w_taken) begin
            flush = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        mux_hz_unit = 1'b0;
        pipe_freeze = 1'b1;
      end
      default: begin
        w_next_state = ST_RUN;
        w_next_wait  = '0;
      end
    endcase
    // Hold everything still while reset is asserted.
    if (!rst) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      mux_hz_unit = 1'b0;
      flush       = 1'b0;
      pipe_freeze = 1'b1;
    end
  end

  assign state     = r_state;
  assign mem_error = (r_state == ST_ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (~pc_write),
    .clr   (clr_cnt),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (flush),
    .clr   (clr_cnt),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rt;
  logic       ID_EX_mem_read;
  logic [1:0] branch;
  logic       equal, mem_req, mem_ready, clr_cnt;
  logic       pc_write, IF_ID_write, mux_hz_unit, flush, pipe_freeze, mem_error;
  logic [1:0] state;
  logic [2:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.REG_W(5), .CNT_W(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .ID_EX_rt(ID_EX_rt),
    .ID_EX_mem_read(ID_EX_mem_read), .branch(branch), .equal(equal),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .mux_hz_unit(mux_hz_unit),
    .flush(flush), .pipe_freeze(pipe_freeze), .mem_error(mem_error),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic idle();
    IF_ID_rs = 5'd1; IF_ID_rt = 5'd2; ID_EX_rt = 5'd3; ID_EX_mem_read = 1'b0;
    branch = 2'b00; equal = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_counters();
    idle(); clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); branch = 2'b11; #1;
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rst_pc_write got %0b exp 0", pc_write); end
    checks++; if (IF_ID_write !== 1'b0 || mux_hz_unit !== 1'b0) begin errors++; $display("FAIL rst_ifid_mux got %0b%0b exp 00", IF_ID_write, mux_hz_unit); end
    checks++; if (flush !== 1'b0 || pipe_freeze !== 1'b1) begin errors++; $display("FAIL rst_flush_freeze got %0b%0b exp 01", flush, pipe_freeze); end
    cyc(); cyc();
    checks++; if (state !== 2'b00 || mem_error !== 1'b0) begin errors++; $display("FAIL rst_state got %0d/%0b exp 0/0", state, mem_error); end
    checks++; if (stall_cnt !== 3'd0 || flush_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    rst = 1'b1; idle(); #1;
    checks++; if ({pc_write, IF_ID_write, mux_hz_unit, flush, pipe_freeze} !== 5'b11100) begin errors++; $display("FAIL run_defaults got %b exp 11100", {pc_write, IF_ID_write, mux_hz_unit, flush, pipe_freeze}); end
    cyc();
  endtask

  task automatic test_load_use();
    idle(); ID_EX_mem_read = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8; #1;
    checks++; if ({pc_write, IF_ID_write, mux_hz_unit} !== 3'b000) begin errors++; $display("FAIL lu_rs_outs got %b exp 000", {pc_write, IF_ID_write, mux_hz_unit}); end
    cyc(); idle();
    checks++; if (stall_cnt !== 3'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
    ID_EX_mem_read = 1'b1; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0; #1;
    checks++; if ({pc_write, mux_hz_unit} !== 2'b11) begin errors++; $display("FAIL lu_r0_nostall got %b exp 11", {pc_write, mux_hz_unit}); end
    cyc(); idle();
    ID_EX_mem_read = 1'b1; ID_EX_rt = 5'd9; IF_ID_rt = 5'd9; #1;
    checks++; if ({pc_write, mux_hz_unit} !== 2'b00) begin errors++; $display("FAIL lu_rt_outs got %b exp 00", {pc_write, mux_hz_unit}); end
    cyc(); idle();
    ID_EX_mem_read = 1'b0; ID_EX_rt = 5'd9; IF_ID_rt = 5'd9; #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_noload got %b exp 1", pc_write); end
    cyc(); idle();
    checks++; if (stall_cnt !== 3'd2) begin errors++; $display("FAIL lu_stall_cnt2 got %0d exp 2", stall_cnt); end
  endtask

  task automatic test_branch();
    clear_counters();
    checks++; if (stall_cnt !== 3'd0 || flush_cnt !== 3'd0) begin errors++; $display("FAIL br_clr got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    branch = 2'b01; equal = 1'b1; #1;
    checks++; if ({flush, pc_write, IF_ID_write} !== 3'b111) begin errors++; $display("FAIL br_beq_taken got %b exp 111", {flush, pc_write, IF_ID_write}); end
    cyc(); idle();
    checks++; if (flush_cnt !== 3'd1) begin errors++; $display("FAIL br_flush_cnt1 got %0d exp 1", flush_cnt); end
    branch = 2'b10; equal = 1'b1; #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_bne_eq got %b exp 0", flush); end
    cyc(); idle();
    branch = 2'b11; equal = 1'b0; #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_jmp got %b exp 1", flush); end
    cyc(); idle();
    branch = 2'b01; equal = 1'b0; #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_beq_ne got %b exp 0", flush); end
    cyc(); idle();
    branch = 2'b10; equal = 1'b0; #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_bne_taken got %b exp 1", flush); end
    cyc(); idle();
    checks++; if (flush_cnt !== 3'd3 || stall_cnt !== 3'd0) begin errors++; $display("FAIL br_cnts got %0d/%0d exp 3/0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_priority();
    clear_counters();
    ID_EX_mem_read = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8; branch = 2'b01; equal = 1'b1; #1;
    checks++; if ({pc_write, mux_hz_unit, flush} !== 3'b000) begin errors++; $display("FAIL pri_lu_over_br got %b exp 000", {pc_write, mux_hz_unit, flush}); end
    cyc();
    ID_EX_mem_read = 1'b0; #1;
    checks++; if ({pc_write, mux_hz_unit, flush} !== 3'b111) begin errors++; $display("FAIL pri_br_after got %b exp 111", {pc_write, mux_hz_unit, flush}); end
    cyc(); idle();
    checks++; if (stall_cnt !== 3'd1 || flush_cnt !== 3'd1) begin errors++; $display("FAIL pri_cnts got %0d/%0d exp 1/1", stall_cnt, flush_cnt); end
  endtask

  task automatic test_mem_wait();
    clear_counters();
    mem_req = 1'b1; mem_ready = 1'b0; ID_EX_mem_read = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8; #1;
    checks++; if ({pipe_freeze, pc_write, IF_ID_write, mux_hz_unit, state} !== 6'b100100) begin errors++; $display("FAIL mw_c1 got %b exp 100100", {pipe_freeze, pc_write, IF_ID_write, mux_hz_unit, state}); end
    cyc();
    idle(); mem_req = 1'b1; branch = 2'b11; #1;
    checks++; if ({pipe_freeze, pc_write, flush, state} !== 5'b10001) begin errors++; $display("FAIL mw_c2 got %b exp 10001", {pipe_freeze, pc_write, flush, state}); end
    cyc();
    branch = 2'b00; #1;
    checks++; if ({pipe_freeze, state} !== 3'b101) begin errors++; $display("FAIL mw_c3 got %b exp 101", {pipe_freeze, state}); end
    cyc();
    mem_ready = 1'b1; #1;
    checks++; if ({pipe_freeze, pc_write, state} !== 4'b0101) begin errors++; $display("FAIL mw_release got %b exp 0101", {pipe_freeze, pc_write, state}); end
    cyc(); idle();
    checks++; if (state !== 2'b00 || stall_cnt !== 3'd3 || flush_cnt !== 3'd0) begin errors++; $display("FAIL mw_after got %0d/%0d/%0d exp 0/3/0", state, stall_cnt, flush_cnt); end
    mem_req = 1'b1; mem_ready = 1'b1; #1;
    checks++; if ({pipe_freeze, pc_write} !== 2'b01) begin errors++; $display("FAIL mw_ready_same got %b exp 01", {pipe_freeze, pc_write}); end
    cyc(); idle();
  endtask

  task automatic test_timeout();
    clear_counters();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (pipe_freeze !== 1'b1 || state === 2'b10) begin errors++; $display("FAIL to_frozen%0d got %b/%0d exp 1/not2", k, pipe_freeze, state); end
      cyc();
    end
    checks++; if (state !== 2'b10 || mem_error !== 1'b1) begin errors++; $display("FAIL to_error got %0d/%0b exp 2/1", state, mem_error); end
    checks++; if (stall_cnt !== 3'd5) begin errors++; $display("FAIL to_stall_cnt got %0d exp 5", stall_cnt); end
    mem_ready = 1'b1; branch = 2'b11; #1;
    checks++; if ({pc_write, IF_ID_write, mux_hz_unit, flush, pipe_freeze} !== 5'b00001) begin errors++; $display("FAIL to_err_outs got %b exp 00001", {pc_write, IF_ID_write, mux_hz_unit, flush, pipe_freeze}); end
    cyc();
    checks++; if (state !== 2'b10 || stall_cnt !== 3'd6) begin errors++; $display("FAIL to_stay got %0d/%0d exp 2/6", state, stall_cnt); end
    cyc(); cyc();
    checks++; if (stall_cnt !== 3'd7 || flush_cnt !== 3'd0) begin errors++; $display("FAIL to_sat got %0d/%0d exp 7/0", stall_cnt, flush_cnt); end
    #1; rst = 1'b0; #1;
    checks++; if (state !== 2'b00 || mem_error !== 1'b0 || stall_cnt !== 3'd0) begin errors++; $display("FAIL to_async_rst got %0d/%0b/%0d exp 0/0/0", state, mem_error, stall_cnt); end
    checks++; if ({pc_write, pipe_freeze} !== 2'b01) begin errors++; $display("FAIL to_rst_outs got %b exp 01", {pc_write, pipe_freeze}); end
    rst = 1'b1; idle(); cyc();
    checks++; if (state !== 2'b00 || pc_write !== 1'b1) begin errors++; $display("FAIL to_after_rst got %0d/%0b exp 0/1", state, pc_write); end
  endtask

  task automatic test_saturation();
    clear_counters();
    ID_EX_mem_read = 1'b1; ID_EX_rt = 5'd12; IF_ID_rs = 5'd12;
    for (int k = 0; k < 9; k++) cyc();
    checks++; if (stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_stall got %0d exp 7", stall_cnt); end
    clr_cnt = 1'b1; cyc();
    checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL sat_clr_prio got %0d exp 0", stall_cnt); end
    idle(); cyc();
    checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL sat_idle got %0d exp 0", stall_cnt); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_priority();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
